uop_debounce2: RTL and testbench

Two-channel input conditioner that sits directly upstream of the 2-input NAND gate stage. It takes raw, asynchronous switch/button levels and produces clean, synchronised, debounced levels x_out/y_out that drive the gate's x and y inputs. It also produces one-cycle edge pulses for each channel and a combined "stable" flag for lab observation.

---
 rtl/uop_debounce2.sv | 143 ++++++++++++++
 tb/tb_uop_debounce2.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uop_debounce2.sv
// uop_debounce2 -- two-channel input conditioner ahead of the 2-input NAND stage.
//
// Takes raw asynchronous switch levels (x_raw, y_raw) and produces synchronised,
// debounced levels that drive the NAND x/y inputs, plus one-cycle edge pulses
// per channel and a combined "stable" flag for lab observation.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous, active-high reset
//   tick           count enable for the debounce counters (tie high to count per clock)
//   x_raw, y_raw   raw asynchronous inputs
//   x_out, y_out   debounced levels (registered)
//   x_rise/x_fall  one-cycle pulses after x_out changes 0->1 / 1->0
//   y_rise/y_fall  same for channel Y
//   stable         both counters idle and both synchronised inputs match their outputs
//
// DEBOUNCE_CYCLES legal range is 1..65535; the counter width is derived from it.

// ---------------------------------------------------------------------------
// Per-channel conditioner: 2-flop synchroniser, debounce counter, edge pulses.
// ---------------------------------------------------------------------------
module uop_debounce2_chan #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic       RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall,
  output logic settled
);

  // Terminal count: the edge that sees cnt at this value (with tick) commits s2.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             at_max;
  logic             fire;

  always_comb begin
    differ  = (s2 != out);
    at_max  = (cnt == CNT_MAX);
    fire    = differ & tick & at_max;
    // Settled only when nothing is pending: no partial count, input agrees.
    settled = (cnt == '0) & ~differ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= RESET_LEVEL;
      s2   <= RESET_LEVEL;
      out  <= RESET_LEVEL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      // Synchroniser runs every edge regardless of tick.
      s1   <= raw;
      s2   <= s1;
      // Pulses land in the cycle right after out changes; s2 is the new level.
      rise <= fire &  s2;
      fall <= fire & ~s2;
      if (!differ) begin
        // Agreement at any point discards a partial count (glitch rejection).
        cnt <= '0;
      end else if (tick) begin
        if (at_max) begin
          out <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top: two independent channels, bit 0 = X, bit 1 = Y.
// ---------------------------------------------------------------------------
module uop_debounce2 #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic x_raw,
  input  logic y_raw,
  output logic x_out,
  output logic y_out,
  output logic x_rise,
  output logic x_fall,
  output logic y_rise,
  output logic y_fall,
  output logic stable
);

  localparam int NUM_CH = 2;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_CH-1:0] raw_v;
  logic [NUM_CH-1:0] out_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;
  logic [NUM_CH-1:0] settled_v;

  assign raw_v = {y_raw, x_raw};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    uop_debounce2_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .raw     (raw_v[ch]),
      .out     (out_v[ch]),
      .rise    (rise_v[ch]),
      .fall    (fall_v[ch]),
      .settled (settled_v[ch])
    );
  end

  assign x_out  = out_v[0];
  assign y_out  = out_v[1];
  assign x_rise = rise_v[0];
  assign x_fall = fall_v[0];
  assign y_rise = rise_v[1];
  assign y_fall = fall_v[1];
  // Combinational from registered state only.
  assign stable = &settled_v;

endmodule

// File: tb/tb_uop_debounce2.sv
module tb_uop_debounce2;

  logic clk, reset, tick, x_raw, y_raw;
  logic x_out, y_out, x_rise, x_fall, y_rise, y_fall, stable;
  logic tick1, x1_raw, y1_raw;
  logic x1_out, y1_out, x1_rise, x1_fall, y1_rise, y1_fall, stable1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input bit ok, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  uop_debounce2 #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .x_raw(x_raw), .y_raw(y_raw),
    .x_out(x_out), .y_out(y_out), .x_rise(x_rise), .x_fall(x_fall),
    .y_rise(y_rise), .y_fall(y_fall), .stable(stable)
  );

  uop_debounce2 #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .tick(tick1), .x_raw(x1_raw), .y_raw(y1_raw),
    .x_out(x1_out), .y_out(y1_out), .x_rise(x1_rise), .x_fall(x1_fall),
    .y_rise(y1_rise), .y_fall(y1_fall), .stable(stable1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; x_raw = 1'b0; y_raw = 1'b0;
    tick1 = 1'b1; x1_raw = 1'b0; y1_raw = 1'b0;

    #2;
    chk("rst_x_out", x_out === 1'b0, x_out, 1'b0);
    chk("rst_y_out", y_out === 1'b0, y_out, 1'b0);
    chk("rst_pulses", {x_rise, x_fall, y_rise, y_fall} === 4'b0000, {x_rise, x_fall, y_rise, y_fall}, 4'b0000);
    chk("rst_stable", stable === 1'b1, stable, 1'b1);
    chk("rst_stable_d1", stable1 === 1'b1, stable1, 1'b1);
    #10 reset = 1'b0;
    adv(2);

    x_raw = 1'b1;
    adv(1);  chk("step_e0_out", x_out === 1'b0, x_out, 1'b0);
    adv(1);  chk("step_e1_stable", stable === 1'b0, stable, 1'b0);
    adv(3);  chk("step_e4_out", x_out === 1'b0, x_out, 1'b0);
             chk("step_e4_stable", stable === 1'b0, stable, 1'b0);
    adv(1);  chk("step_e5_out", x_out === 1'b1, x_out, 1'b1);
             chk("step_e5_rise", x_rise === 1'b1, x_rise, 1'b1);
             chk("step_e5_fall", x_fall === 1'b0, x_fall, 1'b0);
             chk("step_e5_stable", stable === 1'b1, stable, 1'b1);
             chk("step_e5_y", {y_out, y_rise} === 2'b00, {y_out, y_rise}, 2'b00);
    adv(1);  chk("step_e6_rise", x_rise === 1'b0, x_rise, 1'b0);
             chk("step_e6_out", x_out === 1'b1, x_out, 1'b1);

    tick = 1'b0; x_raw = 1'b0;
    adv(2);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b0;
      adv(2);
      chk("gate_hold_out", x_out === 1'b1, x_out, 1'b1);
      chk("gate_hold_stable", stable === 1'b0, stable, 1'b0);
      tick = 1'b1;
      adv(1);
      if (i < 3) begin
        chk("gate_cnt_out", x_out === 1'b1, x_out, 1'b1);
        chk("gate_cnt_fall", x_fall === 1'b0, x_fall, 1'b0);
      end else begin
        chk("gate_fire_out", x_out === 1'b0, x_out, 1'b0);
        chk("gate_fire_fall", x_fall === 1'b1, x_fall, 1'b1);
        chk("gate_fire_rise", x_rise === 1'b0, x_rise, 1'b0);
      end
    end
    tick = 1'b0;
    adv(1);  chk("gate_fall_clear", x_fall === 1'b0, x_fall, 1'b0);
    tick = 1'b1;
    adv(3);

    x_raw = 1'b1;
    adv(3);
    x_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adv(1);
      chk("glitch_out", x_out === 1'b0, x_out, 1'b0);
      chk("glitch_rise", x_rise === 1'b0, x_rise, 1'b0);
    end
    chk("glitch_stable", stable === 1'b1, stable, 1'b1);

    x_raw = 1'b1; adv(1);
    x_raw = 1'b0; adv(1);
    x_raw = 1'b1; adv(1);
    x_raw = 1'b0; adv(1);
    x_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adv(1);
      chk("bounce_wait_out", x_out === 1'b0, x_out, 1'b0);
      chk("bounce_wait_rise", x_rise === 1'b0, x_rise, 1'b0);
    end
    adv(1);  chk("bounce_out", x_out === 1'b1, x_out, 1'b1);
             chk("bounce_rise", x_rise === 1'b1, x_rise, 1'b1);
    adv(1);  chk("bounce_rise_clear", x_rise === 1'b0, x_rise, 1'b0);

    x_raw = 1'b0;
    adv(8);  chk("sim_pre_x", x_out === 1'b0, x_out, 1'b0);
             chk("sim_pre_stable", stable === 1'b1, stable, 1'b1);
    x_raw = 1'b1; y_raw = 1'b1; x1_raw = 1'b1; y1_raw = 1'b1;
    adv(2);  chk("d1_e1_out", {y1_out, x1_out} === 2'b00, {y1_out, x1_out}, 2'b00);
    adv(1);  chk("d1_e2_out", {y1_out, x1_out} === 2'b11, {y1_out, x1_out}, 2'b11);
             chk("d1_e2_rise", {y1_rise, x1_rise} === 2'b11, {y1_rise, x1_rise}, 2'b11);
             chk("d1_e2_stable", stable1 === 1'b1, stable1, 1'b1);
    adv(1);  chk("d1_e3_rise", {y1_rise, x1_rise} === 2'b00, {y1_rise, x1_rise}, 2'b00);
    adv(1);  chk("sim_e4_out", {y_out, x_out} === 2'b00, {y_out, x_out}, 2'b00);
    adv(1);  chk("sim_e5_out", {y_out, x_out} === 2'b11, {y_out, x_out}, 2'b11);
             chk("sim_e5_rise", {y_rise, x_rise} === 2'b11, {y_rise, x_rise}, 2'b11);
             chk("sim_e5_fall", {y_fall, x_fall} === 2'b00, {y_fall, x_fall}, 2'b00);
    adv(1);  chk("sim_e6_rise", {y_rise, x_rise} === 2'b00, {y_rise, x_rise}, 2'b00);

    x_raw = 1'b0; y_raw = 1'b0;
    adv(3);
    chk("mid_pre_out", {y_out, x_out} === 2'b11, {y_out, x_out}, 2'b11);
    #2;
    x_raw = 1'b1; y_raw = 1'b1; reset = 1'b1;
    #1;
    chk("mid_rst_out", {y_out, x_out} === 2'b00, {y_out, x_out}, 2'b00);
    chk("mid_rst_pulses", {x_rise, x_fall, y_rise, y_fall} === 4'b0000, {x_rise, x_fall, y_rise, y_fall}, 4'b0000);
    chk("mid_rst_stable", stable === 1'b1, stable, 1'b1);
    chk("mid_rst_d1_out", {y1_out, x1_out} === 2'b00, {y1_out, x1_out}, 2'b00);
    adv(1);
    #2 reset = 1'b0;
    adv(5);  chk("post_rst_e4_out", {y_out, x_out} === 2'b00, {y_out, x_out}, 2'b00);
    adv(1);  chk("post_rst_e5_out", {y_out, x_out} === 2'b11, {y_out, x_out}, 2'b11);
             chk("post_rst_e5_rise", {y_rise, x_rise} === 2'b11, {y_rise, x_rise}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
